// File: rtl/alarm_pkg.sv
// Shared types for the anti-theft alarm: FSM state encoding and interval indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alarm_pkg;

    localparam int INTERVAL_W = 4;

    typedef logic [INTERVAL_W-1:0] interval_t;
    typedef logic [1:0]            param_idx_t;

    localparam param_idx_t IDX_ARM       = 2'd0;
    localparam param_idx_t IDX_DRIVER    = 2'd1;
    localparam param_idx_t IDX_PASSENGER = 2'd2;
    localparam param_idx_t IDX_ALARM_ON  = 2'd3;

    typedef enum logic [2:0] {
        ARMED,
        TRIGGERED,
        ALARM,
        ALARM_TAIL,
        DISARMED,
        WAIT_OPEN,
        WAIT_CLOSE,
        ARM_DELAY
    } state_t;

endpackage

// File: rtl/alarm_time_params.sv
// Four user-reprogrammable 4-bit intervals with reset defaults.
// Latency: write lands next cycle; read is combinational.
// Backpressure: none, writes always accepted.
module alarm_time_params
    import alarm_pkg::*;
#(
    parameter interval_t ARM_DEF       = 4'd6,
    parameter interval_t DRIVER_DEF    = 4'd8,
    parameter interval_t PASSENGER_DEF = 4'd15,
    parameter interval_t ALARM_ON_DEF  = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       reprogram,
    input  logic [1:0] wr_sel,
    input  logic [3:0] wr_value,
    input  logic [1:0] rd_sel,
    output logic [3:0] rd_value
);

    interval_t param_q [4];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            param_q[IDX_ARM]       <= ARM_DEF;
            param_q[IDX_DRIVER]    <= DRIVER_DEF;
            param_q[IDX_PASSENGER] <= PASSENGER_DEF;
            param_q[IDX_ALARM_ON]  <= ALARM_ON_DEF;
        end else if (reprogram) begin
            param_q[wr_sel] <= wr_value;
        end
    end

    assign rd_value = param_q[rd_sel];

endmodule

// File: rtl/alarm_controller.sv
// Alarm FSM: sequences the countdown timer, drives siren and status LED.
// Latency: every output registered, reacts one cycle after its inputs.
// Backpressure: none; expired is ignored during the start_timer cycle.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter interval_t T_ARM_DELAY_DEF = 4'd6,
    parameter interval_t T_DRIVER_DEF    = 4'd8,
    parameter interval_t T_PASSENGER_DEF = 4'd15,
    parameter interval_t T_ALARM_ON_DEF  = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic       expired,
    input  logic       half_hz_enable,
    output logic       start_timer,
    output logic [3:0] timer_value,
    output logic       siren,
    output logic       status_led
);

    state_t     state_q, state_n;
    logic       start_n, siren_n, led_n;
    param_idx_t rd_sel;
    interval_t  rd_value;
    logic       any_door, exp_live;

    alarm_time_params #(
        .ARM_DEF       (T_ARM_DELAY_DEF),
        .DRIVER_DEF    (T_DRIVER_DEF),
        .PASSENGER_DEF (T_PASSENGER_DEF),
        .ALARM_ON_DEF  (T_ALARM_ON_DEF)
    ) u_params (
        .clock     (clock),
        .reset     (reset),
        .reprogram (reprogram),
        .wr_sel    (time_param_sel),
        .wr_value  (time_value),
        .rd_sel    (rd_sel),
        .rd_value  (rd_value)
    );

    assign any_door = door_driver | door_pass;
    // The timer has not reloaded yet in the start cycle, so its expiry is stale.
    assign exp_live = expired & ~start_timer;

    always_comb begin
        state_n = state_q;
        start_n = 1'b0;
        rd_sel  = IDX_ARM;
        if (reprogram) begin
            state_n = ARMED;
        end else if (ignition && state_q != DISARMED) begin
            state_n = DISARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    if (door_driver) begin
                        state_n = TRIGGERED;
                        start_n = 1'b1;
                        rd_sel  = IDX_DRIVER;
                    end else if (door_pass) begin
                        state_n = TRIGGERED;
                        start_n = 1'b1;
                        rd_sel  = IDX_PASSENGER;
                    end
                end
                TRIGGERED:  if (exp_live) state_n = ALARM;
                ALARM: begin
                    if (!any_door) begin
                        state_n = ALARM_TAIL;
                        start_n = 1'b1;
                        rd_sel  = IDX_ALARM_ON;
                    end
                end
                ALARM_TAIL: begin
                    if (any_door)      state_n = ALARM;
                    else if (exp_live) state_n = ARMED;
                end
                DISARMED:   if (!ignition) state_n = WAIT_OPEN;
                WAIT_OPEN:  if (door_driver) state_n = WAIT_CLOSE;
                WAIT_CLOSE: begin
                    if (!any_door) begin
                        state_n = ARM_DELAY;
                        start_n = 1'b1;
                        rd_sel  = IDX_ARM;
                    end
                end
                ARM_DELAY: begin
                    if (any_door)      state_n = WAIT_CLOSE;
                    else if (exp_live) state_n = ARMED;
                end
                default: state_n = ARMED;
            endcase
        end

        siren_n = (state_n == ALARM) || (state_n == ALARM_TAIL);
        // Blink phase restarts at 0 whenever ARMED is entered from elsewhere.
        led_n = 1'b0;
        case (state_n)
            TRIGGERED, ALARM, ALARM_TAIL: led_n = 1'b1;
            ARMED: led_n = (state_q == ARMED) ? (status_led ^ half_hz_enable) : 1'b0;
            default: led_n = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ARMED;
            start_timer <= 1'b0;
            timer_value <= '0;
            siren       <= 1'b0;
            status_led  <= 1'b0;
        end else begin
            state_q     <= state_n;
            start_timer <= start_n;
            if (start_n) timer_value <= rd_value;
            siren       <= siren_n;
            status_led  <= led_n;
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboarded bench for alarm_controller; the bench plays the timer's role.
// Expected start values are queued at stimulus time and popped on each start pulse.
module tb_alarm_controller;

    logic       clock = 1'b0;
    logic       reset, ignition, door_driver, door_pass, reprogram;
    logic       expired, half_hz_enable;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       start_timer, siren, status_led;
    logic [3:0] timer_value;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] sb_q[$];

    always #5 clock = ~clock;

    alarm_controller dut (
        .clock          (clock),
        .reset          (reset),
        .ignition       (ignition),
        .door_driver    (door_driver),
        .door_pass      (door_pass),
        .reprogram      (reprogram),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .expired        (expired),
        .half_hz_enable (half_hz_enable),
        .start_timer    (start_timer),
        .timer_value    (timer_value),
        .siren          (siren),
        .status_led     (status_led)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Every start pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && start_timer) begin
            if (sb_q.size() == 0) check_val("start_unexpected", start_timer, 0);
            else                  check_val("start_value", timer_value, sb_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1; ignition = 1'b0; door_driver = 1'b0; door_pass = 1'b0;
        reprogram = 1'b0; expired = 1'b0; half_hz_enable = 1'b0;
        time_param_sel = 2'd0; time_value = 4'd0;
        step(2);
        check_val("rst_siren", siren, 0);
        check_val("rst_led", status_led, 0);
        check_val("rst_start", start_timer, 0);
        reset = 1'b0;
        step();

        // blink in ARMED
        for (int i = 0; i < 4; i++) begin
            half_hz_enable = 1'b1;
            step();
            half_hz_enable = 1'b0;
            check_val("t1_led", status_led, (i % 2 == 0) ? 1 : 0);
            check_val("t1_siren", siren, 0);
            step();
        end

        // both doors together: driver interval wins
        door_driver = 1'b1; door_pass = 1'b1;
        sb_q.push_back(4'd8);
        step();
        check_val("t2_start", start_timer, 1);
        check_val("t2_led", status_led, 1);
        check_val("t2_siren", siren, 0);
        door_pass = 1'b0;
        step();
        check_val("t2_pulse_width", start_timer, 0);
        expired = 1'b1;
        step();
        expired = 1'b0;
        check_val("t2_siren_on", siren, 1);

        // ALARM <-> ALARM_TAIL
        step();
        check_val("t4_hold_siren", siren, 1);
        door_driver = 1'b0;
        sb_q.push_back(4'd10);
        step();
        check_val("t4_tail_start", start_timer, 1);
        check_val("t4_tail_siren", siren, 1);
        door_driver = 1'b1;
        step();
        check_val("t4_reopen_nostart", start_timer, 0);
        check_val("t4_reopen_siren", siren, 1);
        door_driver = 1'b0;
        sb_q.push_back(4'd10);
        step();
        check_val("t4_tail_restart", start_timer, 1);
        step();
        expired = 1'b1;
        step();
        expired = 1'b0;
        check_val("t4_armed_siren", siren, 0);
        check_val("t4_armed_led", status_led, 0);

        // passenger trigger, then ignition disarms
        door_pass = 1'b1;
        sb_q.push_back(4'd15);
        step();
        check_val("t3_start", start_timer, 1);
        check_val("t3_led", status_led, 1);
        door_pass = 1'b0;
        step();
        ignition = 1'b1;
        step();
        check_val("t3_dis_siren", siren, 0);
        check_val("t3_dis_led", status_led, 0);
        check_val("t3_dis_nostart", start_timer, 0);

        // re-arm sequence with a door reopening during the arm delay
        ignition = 1'b0;
        step();
        door_driver = 1'b1;
        step();
        door_driver = 1'b0;
        sb_q.push_back(4'd6);
        step();
        check_val("t5_arm_start", start_timer, 1);
        check_val("t5_arm_led", status_led, 0);
        step();
        door_pass = 1'b1;
        step();
        check_val("t5_reopen_nostart", start_timer, 0);
        door_pass = 1'b0;
        sb_q.push_back(4'd6);
        step();
        check_val("t5_arm_restart", start_timer, 1);
        step();
        expired = 1'b1;
        step();
        expired = 1'b0;
        check_val("t5_armed_led", status_led, 0);
        check_val("t5_armed_siren", siren, 0);
        half_hz_enable = 1'b1;
        step();
        half_hz_enable = 1'b0;
        check_val("t5_blink", status_led, 1);

        // reprogram driver interval from ALARM
        door_driver = 1'b1;
        sb_q.push_back(4'd8);
        step();
        check_val("t6_trig_start", start_timer, 1);
        step();
        expired = 1'b1;
        step();
        expired = 1'b0;
        check_val("t6_alarm_siren", siren, 1);
        reprogram = 1'b1; time_param_sel = 2'd1; time_value = 4'd3;
        step();
        reprogram = 1'b0;
        check_val("t6_reprog_siren", siren, 0);
        check_val("t6_reprog_led", status_led, 0);
        check_val("t6_reprog_nostart", start_timer, 0);
        sb_q.push_back(4'd3);
        step();
        check_val("t6_new_start", start_timer, 1);
        door_driver = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check_val("t6_async_rst_led", status_led, 0);
        check_val("t6_async_rst_start", start_timer, 0);
        step();
        reset = 1'b0;
        step();
        door_driver = 1'b1;
        sb_q.push_back(4'd8);
        step();
        check_val("t6_default_start", start_timer, 1);
        door_driver = 1'b0;
        step(3);
        check_val("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
